// File: rtl/clock_core_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clock_pkg
// Purpose  : Shared definitions for the clock_core_mux digital-clock core:
//            7-segment encoder, scan digit indices and the blank pattern.
// Contents : DIG_M/DIG_MM/DIG_H/DIG_HH  - bit positions in dig_sel
//            SEG_BLANK                   - all segments off
//            seg7_encode()               - BCD -> {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam int DIG_M  = 0;
    localparam int DIG_MM = 1;
    localparam int DIG_H  = 2;
    localparam int DIG_HH = 3;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Active-high segments, bit order {g,f,e,d,c,b,a}; non-BCD codes blank.
    function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
        logic [6:0] s;
        case (bcd)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_core_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_core_mux_if
// Purpose  : Control and display bundle of the clock core.
// Signals  : set_min, set_hour, hold        - controls into the core
//            hh, h, mm, m (BCD), ss (binary) - current time
//            pm, sec_tick, colon             - status
//            dig_sel (one-hot), seg          - multiplexed 7-segment scan
// Modports : master - drives controls, observes time/display
//            slave  - the clock core
// Revision : 1.0 - initial release
// ============================================================================
interface clock_core_mux_if;
    logic       set_min;
    logic       set_hour;
    logic       hold;
    logic [3:0] hh;
    logic [3:0] h;
    logic [3:0] mm;
    logic [3:0] m;
    logic [5:0] ss;
    logic       pm;
    logic       sec_tick;
    logic       colon;
    logic [3:0] dig_sel;
    logic [6:0] seg;

    modport master (
        output set_min, set_hour, hold,
        input  hh, h, mm, m, ss, pm, sec_tick, colon, dig_sel, seg
    );

    modport slave (
        input  set_min, set_hour, hold,
        output hh, h, mm, m, ss, pm, sec_tick, colon, dig_sel, seg
    );
endinterface
`default_nettype wire

// File: rtl/clock_core_mux_bcd_digit_cntr.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_cntr
// Purpose  : One decimal digit of the clock: counts 0..MAX and wraps to 0,
//            with a parallel load that takes priority over counting.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            en                - advance by one
//            load, load_val    - overwrite the digit
//            q                 - current digit value
//            cy                - carry out, en && q==MAX (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_cntr #(
    parameter logic [3:0] MAX     = 4'd9,
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    input  wire logic       load,
    input  wire logic [3:0] load_val,
    output logic      [3:0] q,
    output logic            cy
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign cy = en && (q_q == MAX);

endmodule
`default_nettype wire

// File: rtl/clock_core_mux.sv
`default_nettype none
// ============================================================================
// Module   : clock_core_mux
// Purpose  : HH:MM:SS clock core with 12/24-hour mode, programmable
//            prescaler, set inputs and a 4-digit 7-segment scan driver.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            cif  - clock_core_mux_if.slave (controls, time, display)
// Params   : PRESCALE - clk cycles per second (>= 2)
//            MODE_12H - 0: 00..23, 1: 12,01..11 with pm flag
//            HIDE_LZ  - blank the hour-tens digit when it is zero
//            SCAN_W   - scan advances one digit every 2^SCAN_W cycles
// Revision : 1.0 - initial release
// ============================================================================
module clock_core_mux
    import clock_pkg::*;
#(
    parameter int PRESCALE = 32768,
    parameter int MODE_12H = 0,
    parameter int HIDE_LZ  = 1,
    parameter int SCAN_W   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    clock_core_mux_if.slave   cif
);

    localparam int               PRE_W    = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(PRESCALE / 2);
    localparam logic [3:0]       HH_RST   = (MODE_12H != 0) ? 4'd1 : 4'd0;
    localparam logic [3:0]       H_RST    = (MODE_12H != 0) ? 4'd2 : 4'd0;

    // ------------------------------------------------------------------
    // Prescaler and tick qualification
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_raw;
    logic             tick_ok;

    assign tick_raw = !cif.hold && (pre_q == PRE_LAST);
    // A set pulse in the wrap cycle swallows that second entirely.
    assign tick_ok  = tick_raw && !cif.set_min && !cif.set_hour;

    always_comb begin
        pre_d = pre_q;
        if (cif.set_min) begin
            pre_d = '0;
        end else if (!cif.hold) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Seconds / minutes digit chain
    // ------------------------------------------------------------------
    logic [3:0] su_q, st_q, m_q, mm_q, h_q, hh_q;
    logic       cy_su, cy_st, cy_m, cy_mm, cy_h, cy_hh;
    logic       min_en;
    logic       hour_adv;

    // set_min bumps minutes but its mm carry must not reach the hours.
    assign min_en   = cif.set_min || cy_st;
    assign hour_adv = cif.set_hour || (tick_ok && cy_mm);

    bcd_digit_cntr #(.MAX(4'd9), .RST_VAL(4'd0)) u_sec_u (
        .clk(clk), .rst(rst), .en(tick_ok), .load(cif.set_min),
        .load_val(4'd0), .q(su_q), .cy(cy_su)
    );

    bcd_digit_cntr #(.MAX(4'd5), .RST_VAL(4'd0)) u_sec_t (
        .clk(clk), .rst(rst), .en(cy_su), .load(cif.set_min),
        .load_val(4'd0), .q(st_q), .cy(cy_st)
    );

    bcd_digit_cntr #(.MAX(4'd9), .RST_VAL(4'd0)) u_min_u (
        .clk(clk), .rst(rst), .en(min_en), .load(1'b0),
        .load_val(4'd0), .q(m_q), .cy(cy_m)
    );

    bcd_digit_cntr #(.MAX(4'd5), .RST_VAL(4'd0)) u_min_t (
        .clk(clk), .rst(rst), .en(cy_m), .load(1'b0),
        .load_val(4'd0), .q(mm_q), .cy(cy_mm)
    );

    // ------------------------------------------------------------------
    // Hours: the wrap rule differs per mode, so the next hour is computed
    // here and loaded into both digits in one edge.
    // ------------------------------------------------------------------
    logic [3:0] hh_nx, h_nx;
    logic       pm_q, pm_d;

    always_comb begin
        hh_nx = hh_q;
        h_nx  = h_q + 4'd1;
        pm_d  = pm_q;
        if (MODE_12H != 0) begin
            if (hh_q == 4'd1 && h_q == 4'd2) begin
                hh_nx = 4'd0;
                h_nx  = 4'd1;
            end else if (hh_q == 4'd1 && h_q == 4'd1) begin
                h_nx = 4'd2;
                if (hour_adv) begin
                    pm_d = !pm_q;
                end
            end else if (h_q == 4'd9) begin
                hh_nx = 4'd1;
                h_nx  = 4'd0;
            end
        end else begin
            if (hh_q == 4'd2 && h_q == 4'd3) begin
                hh_nx = 4'd0;
                h_nx  = 4'd0;
            end else if (h_q == 4'd9) begin
                hh_nx = hh_q + 4'd1;
                h_nx  = 4'd0;
            end
        end
    end

    bcd_digit_cntr #(.MAX(4'd9), .RST_VAL(H_RST)) u_hour_u (
        .clk(clk), .rst(rst), .en(1'b0), .load(hour_adv),
        .load_val(h_nx), .q(h_q), .cy(cy_h)
    );

    bcd_digit_cntr #(.MAX(4'd2), .RST_VAL(HH_RST)) u_hour_t (
        .clk(clk), .rst(rst), .en(1'b0), .load(hour_adv),
        .load_val(hh_nx), .q(hh_q), .cy(cy_hh)
    );

    logic unused_cy;
    assign unused_cy = cy_h ^ cy_hh;

    // ------------------------------------------------------------------
    // Display scan: seg is derived from the next dig_sel so the enable
    // and its pattern switch on the same edge.
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [3:0]        dig_q, dig_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        digit;

    always_comb begin
        scan_d = scan_q + 1'b1;
        dig_d  = (&scan_q) ? {dig_q[2:0], dig_q[3]} : dig_q;

        if (dig_d[DIG_HH]) begin
            digit = hh_q;
        end else if (dig_d[DIG_H]) begin
            digit = h_q;
        end else if (dig_d[DIG_MM]) begin
            digit = mm_q;
        end else begin
            digit = m_q;
        end

        seg_d = seg7_encode(digit);
        if ((HIDE_LZ != 0) && dig_d[DIG_HH] && (hh_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
    end

    // ------------------------------------------------------------------
    // Registered status and scan outputs
    // ------------------------------------------------------------------
    logic sec_tick_q;
    logic colon_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            pm_q       <= 1'b0;
            sec_tick_q <= 1'b0;
            colon_q    <= 1'b1;
            scan_q     <= '0;
            dig_q      <= 4'b0001;
            seg_q      <= 7'h3F;
        end else begin
            pre_q      <= pre_d;
            pm_q       <= pm_d;
            sec_tick_q <= tick_ok;
            colon_q    <= (pre_d < PRE_HALF);
            scan_q     <= scan_d;
            dig_q      <= dig_d;
            seg_q      <= seg_d;
        end
    end

    assign cif.hh       = hh_q;
    assign cif.h        = h_q;
    assign cif.mm       = mm_q;
    assign cif.m        = m_q;
    assign cif.ss       = 6'(st_q) * 6'd10 + 6'(su_q);
    assign cif.pm       = pm_q;
    assign cif.sec_tick = sec_tick_q;
    assign cif.colon    = colon_q;
    assign cif.dig_sel  = dig_q;
    assign cif.seg      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_core_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_core_mux
// Purpose  : Directed self-checking bench for clock_core_mux.
//            dut_a: PRESCALE=4, 24h, HIDE_LZ=1, SCAN_W=1
//            dut_b: PRESCALE=4, 12h, HIDE_LZ=1, SCAN_W=4
//            Expected times are queued as stimulus is driven and popped
//            when the corresponding DUT state is sampled (on negedge).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_core_mux;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    clock_core_mux_if if_a ();
    clock_core_mux_if if_b ();

    clock_core_mux #(.PRESCALE(4), .MODE_12H(0), .HIDE_LZ(1), .SCAN_W(1)) dut_a (
        .clk(clk), .rst(rst_a), .cif(if_a)
    );

    clock_core_mux #(.PRESCALE(4), .MODE_12H(1), .HIDE_LZ(1), .SCAN_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .cif(if_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [22:0] exp_q[$];
    string       tag_q[$];

    // Expected packing: {hh, h, mm, m, ss, pm}
    task automatic expect_t(input string tag, input logic [3:0] hh, input logic [3:0] h,
                            input logic [3:0] mm, input logic [3:0] m,
                            input logic [5:0] ss, input logic pm);
        exp_q.push_back({hh, h, mm, m, ss, pm});
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [22:0] obs);
        logic [22:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h required=queued expectation", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h%h:%h%h ss=%0d pm=%b required=%h%h:%h%h ss=%0d pm=%b",
                   t, obs[22:19], obs[18:15], obs[14:11], obs[10:7], obs[6:1], obs[0],
                   e[22:19], e[18:15], e[14:11], e[10:7], e[6:1], e[0]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] obs_a();
        return {if_a.hh, if_a.h, if_a.mm, if_a.m, if_a.ss, if_a.pm};
    endfunction

    function automatic logic [22:0] obs_b();
        return {if_b.hh, if_b.h, if_b.mm, if_b.m, if_b.ss, if_b.pm};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // n back-to-back single-cycle set pulses on the chosen DUT
    task automatic pulses(input bit sel_b, input bit hour, input int n);
        repeat (n) begin
            if (sel_b) begin
                if (hour) if_b.set_hour = 1'b1; else if_b.set_min = 1'b1;
            end else begin
                if (hour) if_a.set_hour = 1'b1; else if_a.set_min = 1'b1;
            end
            @(negedge clk);
        end
        if_a.set_hour = 1'b0; if_a.set_min = 1'b0;
        if_b.set_hour = 1'b0; if_b.set_min = 1'b0;
    endtask

    logic [6:0] seg_tab [4] = '{7'h4F, 7'h5B, 7'h06, 7'h00};

    initial begin
        int ticks;
        int idx;

        rst_a = 1'b1; rst_b = 1'b1;
        if_a.set_min = 1'b0; if_a.set_hour = 1'b0; if_a.hold = 1'b0;
        if_b.set_min = 1'b0; if_b.set_hour = 1'b0; if_b.hold = 1'b0;
        cyc(2);

        // ---------------- dut_a: reset state ----------------
        expect_t("a_reset_time", 0, 0, 0, 0, 0, 0); sb_check(obs_a());
        chk("a_reset_dig_sel",  if_a.dig_sel,  4'b0001);
        chk("a_reset_seg",      if_a.seg,      7'h3F);
        chk("a_reset_colon",    if_a.colon,    1'b1);
        chk("a_reset_sec_tick", if_a.sec_tick, 1'b0);

        // ---------------- dut_a: 240 free-running cycles ----------------
        rst_a = 1'b0;
        ticks = 0;
        for (int c = 1; c <= 240; c++) begin
            @(negedge clk);
            if (if_a.sec_tick) ticks++;
            if (c == 2) chk("a_colon_low_half", if_a.colon, 1'b0);
            if (c == 3) chk("a_no_tick_yet", if_a.ss, 6'd0);
            if (c == 4) begin
                expect_t("a_first_tick", 0, 0, 0, 0, 1, 0); sb_check(obs_a());
                chk("a_colon_new_second", if_a.colon, 1'b1);
            end
            if (c == 236) begin
                expect_t("a_ss59", 0, 0, 0, 0, 59, 0); sb_check(obs_a());
            end
            if (c == 240) begin
                expect_t("a_min_carry", 0, 0, 0, 1, 0, 0); sb_check(obs_a());
            end
        end
        chk("a_sec_tick_count", ticks, 60);

        // ---------------- dut_a: 23:59:59 -> 00:00:00 ----------------
        if_a.hold = 1'b1;
        pulses(0, 1, 23);
        expect_t("a_set_23h", 2, 3, 0, 1, 0, 0); sb_check(obs_a());
        pulses(0, 0, 58);
        if_a.hold = 1'b0;
        expect_t("a_set_2359", 2, 3, 5, 9, 0, 0); sb_check(obs_a());
        cyc(236);
        expect_t("a_235959", 2, 3, 5, 9, 59, 0); sb_check(obs_a());
        cyc(4);
        expect_t("a_day_wrap", 0, 0, 0, 0, 0, 0); sb_check(obs_a());
        chk("a_day_wrap_tick", if_a.sec_tick, 1'b1);

        // ---------------- dut_a: set_min coincident with wrap ----------------
        if_a.hold = 1'b1;
        pulses(0, 1, 10);
        pulses(0, 0, 58);
        if_a.hold = 1'b0;
        cyc(120);
        expect_t("a_105830", 1, 0, 5, 8, 30, 0); sb_check(obs_a());
        cyc(3);
        if_a.set_min = 1'b1;
        @(negedge clk);
        if_a.set_min = 1'b0;
        expect_t("a_setmin_beats_tick", 1, 0, 5, 9, 0, 0); sb_check(obs_a());
        chk("a_dropped_tick", if_a.sec_tick, 1'b0);
        cyc(3);
        expect_t("a_before_next_tick", 1, 0, 5, 9, 0, 0); sb_check(obs_a());
        cyc(1);
        expect_t("a_next_tick", 1, 0, 5, 9, 1, 0); sb_check(obs_a());
        chk("a_next_tick_pulse", if_a.sec_tick, 1'b1);

        // ---------------- dut_a: hold ----------------
        if_a.hold = 1'b1;
        ticks = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 5) if_a.set_hour = 1'b1;
            @(negedge clk);
            if_a.set_hour = 1'b0;
            if (if_a.sec_tick) ticks++;
            if (c == 5) begin
                expect_t("a_hold_set_hour", 1, 1, 5, 9, 1, 0); sb_check(obs_a());
            end
        end
        chk("a_hold_ticks", ticks, 0);
        expect_t("a_hold_end", 1, 1, 5, 9, 1, 0); sb_check(obs_a());
        if_a.hold = 1'b0;
        cyc(4);
        expect_t("a_after_hold", 1, 1, 5, 9, 2, 0); sb_check(obs_a());

        // ---------------- dut_a: scan at 01:23 ----------------
        rst_a = 1'b1;
        cyc(1);
        rst_a = 1'b0;
        if_a.hold = 1'b1;
        pulses(0, 1, 1);                               // edge 1
        expect_t("a_set_latency", 0, 1, 0, 0, 0, 0); sb_check(obs_a());
        pulses(0, 0, 23);                              // edges 2..24
        expect_t("a_scan_time", 0, 1, 2, 3, 0, 0); sb_check(obs_a());
        for (int k = 25; k <= 45; k++) begin
            @(negedge clk);
            idx = (k / 2) % 4;
            chk("a_scan_dig_sel", if_a.dig_sel, 4'b0001 << idx);
            chk("a_scan_seg", if_a.seg, seg_tab[idx]);
        end
        rst_a = 1'b1;
        #1;
        chk("a_async_rst_dig_sel", if_a.dig_sel, 4'b0001);
        chk("a_async_rst_seg", if_a.seg, 7'h3F);
        expect_t("a_async_rst_time", 0, 0, 0, 0, 0, 0); sb_check(obs_a());
        if_a.hold = 1'b0;

        // ---------------- dut_b: 12-hour mode ----------------
        expect_t("b_reset_time", 1, 2, 0, 0, 0, 0); sb_check(obs_b());
        @(negedge clk);
        rst_b = 1'b0;
        if_b.hold = 1'b1;
        pulses(1, 1, 1);
        expect_t("b_12_to_01", 0, 1, 0, 0, 0, 0); sb_check(obs_b());
        pulses(1, 1, 10);
        expect_t("b_set_11am", 1, 1, 0, 0, 0, 0); sb_check(obs_b());
        pulses(1, 0, 59);
        if_b.hold = 1'b0;
        cyc(236);
        expect_t("b_115959", 1, 1, 5, 9, 59, 0); sb_check(obs_b());
        cyc(4);
        expect_t("b_noon_pm", 1, 2, 0, 0, 0, 1); sb_check(obs_b());

        if_b.hold = 1'b1;
        pulses(1, 0, 59);
        if_b.hold = 1'b0;
        expect_t("b_set_1259", 1, 2, 5, 9, 0, 1); sb_check(obs_b());
        cyc(236);
        expect_t("b_125959", 1, 2, 5, 9, 59, 1); sb_check(obs_b());
        cyc(4);
        expect_t("b_one_pm", 0, 1, 0, 0, 0, 1); sb_check(obs_b());
        chk("b_sec_tick", if_b.sec_tick, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
